// File: rtl/majority_bist_if.sv
// Signal bundle between the BIST controller (slave) and the harness hosting the majority circuit.
interface majority_bist_if #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = WIDTH + 1
);
  logic             start;
  logic [WIDTH-1:0] bist_seq;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0] first_err_seq;

  modport master (
    output start, dut_out,
    input  bist_seq, busy, done, pass, err_cnt, first_err_seq
  );

  modport slave (
    input  start, dut_out,
    output bist_seq, busy, done, pass, err_cnt, first_err_seq
  );
endinterface

// File: rtl/majority_bist.sv
// Exhaustive self-test of a WIDTH-input majority circuit: sweeps all patterns, compares the
// circuit's output against an internal golden vote after DUT_LAT cycles, and reports results.
module majority_bist #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned DUT_LAT = 0,
  parameter int unsigned CNT_W   = WIDTH + 1
) (
  input logic            clk,
  input logic            rst,
  majority_bist_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [3:0] DrainLast = (DUT_LAT == 0) ? 4'd0 : 4'(DUT_LAT - 1);
  localparam logic [4:0] MajThr    = 5'(WIDTH / 2 + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] seq_q, seq_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [3:0]       drain_q, drain_d;
  logic             pass_q, pass_d;
  logic             run, clear, golden, mism;
  logic [4:0]       pop;
  logic             al_vld, al_exp;
  logic [WIDTH-1:0] al_seq;

  assign run = (state_q == StRun);

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) pop = pop + 5'(seq_q[i]);
    golden = (pop >= MajThr);
  end

  // Expected results travel alongside the DUT so each compare sees its own pattern.
  if (DUT_LAT == 0) begin : g_comb
    assign al_vld = run;
    assign al_exp = golden;
    assign al_seq = seq_q;
  end else begin : g_pipe
    logic [DUT_LAT-1:0] vld_q, exp_q;
    logic [WIDTH-1:0]   pseq_q [DUT_LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        exp_q <= '0;
        for (int unsigned i = 0; i < DUT_LAT; i++) pseq_q[i] <= '0;
      end else begin
        vld_q[0]  <= run;
        exp_q[0]  <= golden;
        pseq_q[0] <= seq_q;
        for (int unsigned i = 1; i < DUT_LAT; i++) begin
          vld_q[i]  <= vld_q[i-1];
          exp_q[i]  <= exp_q[i-1];
          pseq_q[i] <= pseq_q[i-1];
        end
      end
    end

    assign al_vld = vld_q[DUT_LAT-1];
    assign al_exp = exp_q[DUT_LAT-1];
    assign al_seq = pseq_q[DUT_LAT-1];
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    drain_d = drain_q;
    clear   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          seq_d   = '0;
          clear   = 1'b1;
        end
      end
      StRun: begin
        if (seq_q == '1) begin
          state_d = (DUT_LAT == 0) ? StDone : StDrain;
          drain_d = '0;
        end else begin
          seq_d = seq_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) state_d = StDone;
        else                      drain_d = drain_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mism = al_vld && (bus.dut_out != al_exp);

  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    if (clear) begin
      err_d   = '0;
      first_d = '0;
      pass_d  = 1'b0;
    end else if (mism) begin
      if (err_q == '0) first_d = al_seq;
      if (err_q != '1) err_d = err_q + 1'b1;
    end
    // Uses err_d so a mismatch on the final compare still lands in pass.
    if (state_d == StDone && state_q != StDone) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      seq_q   <= '0;
      drain_q <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.bist_seq      = seq_q;
  assign bus.busy          = (state_q == StRun) || (state_q == StDrain);
  assign bus.done          = (state_q == StDone);
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_seq = first_q;
endmodule

// File: tb/tb_majority_bist.sv
// Bench: four BIST instances (W5 comb, W5 two-stage, W5 misconfigured latency, W4 comb)
// driven by faultable majority models; sweep results are checked against a pattern-level model.
module tb_majority_bist;
  localparam int NI = 4;

  typedef struct {
    int err;
    int first;
    int pass;
    int cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  majority_bist_if #(.WIDTH(5), .CNT_W(6)) if0 ();
  majority_bist_if #(.WIDTH(5), .CNT_W(6)) if1 ();
  majority_bist_if #(.WIDTH(5), .CNT_W(6)) if2 ();
  majority_bist_if #(.WIDTH(4), .CNT_W(5)) if3 ();

  majority_bist #(.WIDTH(5), .DUT_LAT(0), .CNT_W(6)) u0 (.clk(clk), .rst(rst), .bus(if0));
  majority_bist #(.WIDTH(5), .DUT_LAT(2), .CNT_W(6)) u1 (.clk(clk), .rst(rst), .bus(if1));
  majority_bist #(.WIDTH(5), .DUT_LAT(1), .CNT_W(6)) u2 (.clk(clk), .rst(rst), .bus(if2));
  majority_bist #(.WIDTH(4), .DUT_LAT(0), .CNT_W(5)) u3 (.clk(clk), .rst(rst), .bus(if3));

  int   mode [NI];  // 0 ideal, 1 stuck0, 2 invert on all-ones, 3 invert on fpat, 4 stuck1
  int   fpat [NI];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   prev2 = 0;
  exp_t q0[$], q1[$], q2[$], q3[$];

  function automatic int maj(int w, int p);
    return ($countones(p) >= w / 2 + 1) ? 1 : 0;
  endfunction

  function automatic int resp_bit(int i, int w, int p);
    int g = maj(w, p);
    case (mode[i])
      1:       return 0;
      2:       return g ^ ((p == (1 << w) - 1) ? 1 : 0);
      3:       return g ^ ((p == fpat[i]) ? 1 : 0);
      4:       return 1;
      default: return g;
    endcase
  endfunction

  // Compare for pattern k sees the response to pattern k-shift; before the sweep the circuit
  // has been looking at the held pre-start pattern.
  function automatic exp_t ref_model(int i, int w, int lcfg, int ldut, int prev);
    exp_t e;
    int   n = 1 << w;
    int   src;
    e.err   = 0;
    e.first = 0;
    for (int k = 0; k < n; k++) begin
      src = (k - (ldut - lcfg) >= 0) ? k - (ldut - lcfg) : prev;
      if (resp_bit(i, w, src) != maj(w, k)) begin
        if (e.err == 0) e.first = k;
        e.err++;
      end
    end
    e.pass   = (e.err == 0) ? 1 : 0;
    e.cycles = n + lcfg;
    return e;
  endfunction

  // Harness-side majority circuits.
  logic [1:0] r1, r2;
  always_comb begin
    if0.dut_out = (resp_bit(0, 5, int'(if0.bist_seq)) != 0);
    if3.dut_out = (resp_bit(3, 4, int'(if3.bist_seq)) != 0);
  end
  always @(posedge clk) begin
    r1[0] <= (resp_bit(1, 5, int'(if1.bist_seq)) != 0);
    r2[0] <= r1[0];
    r1[1] <= (resp_bit(2, 5, int'(if2.bist_seq)) != 0);
    r2[1] <= r1[1];
  end
  assign if1.dut_out = r2[0];
  assign if2.dut_out = r2[1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(int i, string name, int got, int want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0d expected %0d", i, name, got, want);
    end
  endtask

  task automatic on_done(int i, int err, int first, int ps);
    exp_t e;
    bit   ok = 1'b1;
    case (i)
      0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      2: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
      default: if (q3.size() > 0) e = q3.pop_front(); else ok = 1'b0;
    endcase
    if (!ok) begin
      check(i, "done_without_pending_sweep", 1, 0);
    end else begin
      check(i, "err_cnt", err, e.err);
      check(i, "first_err_seq", first, e.first);
      check(i, "pass", ps, e.pass);
      check(i, "sweep_cycles", cyc - start_cyc - 1, e.cycles);
    end
  endtask

  // Monitor: pops the scoreboard whenever an instance raises done.
  logic [NI-1:0] dprev = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (if0.done && !dprev[0]) on_done(0, int'(if0.err_cnt), int'(if0.first_err_seq), int'(if0.pass));
      if (if1.done && !dprev[1]) on_done(1, int'(if1.err_cnt), int'(if1.first_err_seq), int'(if1.pass));
      if (if2.done && !dprev[2]) on_done(2, int'(if2.err_cnt), int'(if2.first_err_seq), int'(if2.pass));
      if (if3.done && !dprev[3]) on_done(3, int'(if3.err_cnt), int'(if3.first_err_seq), int'(if3.pass));
    end
    dprev <= {if3.done, if2.done, if1.done, if0.done};
  end

  task automatic set_start(logic v);
    if0.start = v;
    if1.start = v;
    if2.start = v;
    if3.start = v;
  endtask

  task automatic check_reset_state();
    check(0, "rst_outputs", int'({if0.bist_seq, if0.busy, if0.done, if0.pass, if0.err_cnt, if0.first_err_seq}), 0);
    check(1, "rst_outputs", int'({if1.bist_seq, if1.busy, if1.done, if1.pass, if1.err_cnt, if1.first_err_seq}), 0);
    check(2, "rst_outputs", int'({if2.bist_seq, if2.busy, if2.done, if2.pass, if2.err_cnt, if2.first_err_seq}), 0);
    check(3, "rst_outputs", int'({if3.bist_seq, if3.busy, if3.done, if3.pass, if3.err_cnt, if3.first_err_seq}), 0);
  endtask

  task automatic run_round(int m0, int m1, int m2, int m3, bit extra, int rst_at);
    mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
    fpat[0] = $urandom_range(0, 31); fpat[1] = $urandom_range(0, 31);
    fpat[2] = $urandom_range(0, 31); fpat[3] = $urandom_range(0, 15);
    repeat (3) @(negedge clk);
    q0.push_back(ref_model(0, 5, 0, 0, 0));
    q1.push_back(ref_model(1, 5, 2, 2, 0));
    q2.push_back(ref_model(2, 5, 1, 2, prev2));
    q3.push_back(ref_model(3, 4, 0, 0, 0));
    set_start(1'b1);
    start_cyc = cyc;
    @(negedge clk);
    set_start(1'b0);
    check(0, "busy_after_start", int'({if0.busy, if0.done}), 2);
    check(3, "busy_after_start", int'({if3.busy, if3.done}), 2);
    if (rst_at > 0) begin
      repeat (rst_at - 1) @(negedge clk);
      rst = 1'b1;
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset_state();
      prev2 = 0;
      return;
    end
    if (extra) begin
      repeat ($urandom_range(1, 12)) @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
    end
    for (int t = 0; t < 200 && !(if0.done && if1.done && if2.done && if3.done); t++)
      @(negedge clk);
    if (!(if0.done && if1.done && if2.done && if3.done)) check(0, "done_timeout", 0, 1);
    @(negedge clk);
    check(0, "pending_after_sweep", q0.size() + q1.size() + q2.size() + q3.size(), 0);
    prev2 = 31;
  endtask

  initial begin
    rst = 1'b1;
    set_start(1'b0);
    for (int i = 0; i < NI; i++) begin
      mode[i] = 0;
      fpat[i] = 0;
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check_reset_state();

    run_round(0, 0, 0, 0, 1'b0, 0);  // ideal everywhere
    run_round(1, 0, 0, 0, 1'b0, 0);  // stuck-at-0 on inst0
    run_round(2, 2, 0, 2, 1'b0, 0);  // fault only on the last pattern
    run_round(0, 0, 0, 0, 1'b0, 10); // reset mid-sweep
    run_round(0, 0, 0, 0, 1'b1, 0);  // start during RUN is ignored
    run_round(0, 0, 0, 0, 1'b0, 0);  // rerun from DONE
    for (int r = 0; r < 8; r++)
      run_round($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
